// File: rtl/bram_pkg.sv
// bram_pkg: shared constants and helpers for the simple-dual-port BRAM wrapper
//   RDW_* : read-during-write mode selectors
//   merge_bytes() : byte-lane merge used by the write path and the write-first bypass
//   params_ok() : parameter legality predicate evaluated at elaboration
package bram_pkg;
   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;
   localparam int MAX_W = 1024;
   localparam int MAX_B = MAX_W / 8;

   // Operates at MAX_W so one function serves any WIDTH; callers zero-extend and truncate.
   function automatic logic [MAX_W-1:0] merge_bytes(input logic [MAX_W-1:0] old_w,
                                                    input logic [MAX_W-1:0] new_w,
                                                    input logic [MAX_B-1:0] strb);
      logic [MAX_W-1:0] m;
      for (int i = 0; i < MAX_B; i++) m[8*i+:8] = strb[i] ? new_w[8*i+:8] : old_w[8*i+:8];
      return m;
   endfunction

   function automatic bit params_ok(input int width, input int depth, input int latency, input int rdw);
      return width > 0 && width % 8 == 0 && width <= MAX_W && depth >= 2 &&
             latency >= 1 && latency <= 3 && (rdw == RDW_READ_FIRST || rdw == RDW_WRITE_FIRST);
   endfunction
endpackage

// File: rtl/bram_rd_fifo.sv
// bram_rd_fifo: synchronous FIFO, any depth >= 2, occupancy count tells full from empty
//   push/din : write side (caller guarantees no push when full)
//   pop/dout : read side (dout is the head word, valid while count != 0)
//   count    : current occupancy
module bram_rd_fifo
#(
   parameter int W = 32,
   parameter int D = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           dout,
   output logic [$clog2(D+1)-1:0] count
);
   localparam int PW = $clog2(D);
   localparam int CW = $clog2(D+1);
   logic [W-1:0]  mem_q [D];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Pointers wrap at D, which need not be a power of two.
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(D-1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wp_d  = reset ? '0 : push ? inc(wp_q) : wp_q;
      rp_d  = reset ? '0 : pop ? inc(rp_q) : rp_q;
      cnt_d = reset ? '0 : cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      if (reset) mem_q <= '{default: '0};
      else if (push) mem_q[wp_q] <= din;
   end

   assign dout  = mem_q[rp_q];
   assign count = cnt_q;
endmodule

// File: rtl/bram_sdp_flow.sv
// bram_sdp_flow: simple-dual-port BRAM with LATENCY read registers and a credit-managed
// ready/valid read-response path
//   w_valid/w_address/w_strb/w_data : byte-masked write, always accepted
//   ar_valid/ar_ready/ar_address    : read request handshake
//   r_valid/r_ready/r_data          : in-order read responses with backpressure
module bram_sdp_flow
   import bram_pkg::*;
#(
   parameter  int WIDTH      = 32,
   parameter  int DEPTH      = 1024,
   parameter  int LATENCY    = 1,
   parameter  int RDW_MODE   = 0,
   localparam int AW         = $clog2(DEPTH),
   localparam int BE         = WIDTH / 8,
   localparam int FIFO_DEPTH = LATENCY + 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             w_valid,
   input  logic [AW-1:0]    w_address,
   input  logic [BE-1:0]    w_strb,
   input  logic [WIDTH-1:0] w_data,
   input  logic             ar_valid,
   output logic             ar_ready,
   input  logic [AW-1:0]    ar_address,
   output logic             r_valid,
   input  logic             r_ready,
   output logic [WIDTH-1:0] r_data
);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int AW1 = AW + 1;
   localparam logic [AW:0] DEPTH_L = AW1'(DEPTH);

   if (!params_ok(WIDTH, DEPTH, LATENCY, RDW_MODE)) begin : g_bad_params
      $error("bram_sdp_flow: illegal WIDTH/DEPTH/LATENCY/RDW_MODE");
   end

   (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0]   pd_q [LATENCY];
   logic [WIDTH-1:0]   pd_d [LATENCY];
   logic [LATENCY-1:0] pv_q, pv_d;
   logic [CW-1:0]      cr_q, cr_d, count;
   logic [WIDTH-1:0]   w_merged, rd_word;
   logic               w_ok, ar_ok, same, accept, pop;

   assign w_ok     = w_valid && ({1'b0, w_address} < DEPTH_L);
   assign ar_ok    = {1'b0, ar_address} < DEPTH_L;
   assign same     = w_ok && ar_ok && (w_address == ar_address);
   assign ar_ready = (cr_q != '0) && !reset;
   assign accept   = ar_valid && ar_ready;
   assign r_valid  = count != '0;
   assign pop      = r_valid && r_ready;
   assign w_merged = WIDTH'(merge_bytes(MAX_W'(mem[w_address]), MAX_W'(w_data), MAX_B'(w_strb)));

   // The write-first bypass reuses the write-path merge: on a same-address hit it is
   // exactly the word the array will hold after this edge.
   always_comb begin
      rd_word = !ar_ok ? '0 : (RDW_MODE == RDW_WRITE_FIRST && same) ? w_merged : mem[ar_address];
      pd_d[0] = rd_word;
      pv_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) begin
         pd_d[i] = pd_q[i-1];
         pv_d[i] = pv_q[i-1] && !reset;
      end
      cr_d = reset ? CW'(FIFO_DEPTH) : cr_q + CW'(pop) - CW'(accept);
   end

   always_ff @(posedge clk) begin
      pd_q <= pd_d;
      pv_q <= pv_d;
      cr_q <= cr_d;
   end

   always_ff @(posedge clk) begin
      if (w_ok) mem[w_address] <= w_merged;
   end

   bram_rd_fifo #(.W(WIDTH), .D(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (pv_q[LATENCY-1]),
      .din   (pd_q[LATENCY-1]),
      .pop   (pop),
      .dout  (r_data),
      .count (count)
   );
endmodule

// File: tb/tb_bram_sdp_flow.sv
// tb_bram_sdp_flow: directed bench driving a READ_FIRST/LATENCY=2 and a
// WRITE_FIRST/LATENCY=3 instance (both DEPTH=10) from the same stimulus
module tb_bram_sdp_flow;
   logic        clk = 0, reset = 1;
   logic        w_valid = 0, ar_valid = 0, r_ready = 0;
   logic [3:0]  w_address = 0, w_strb = 0, ar_address = 0;
   logic [31:0] w_data = 0;
   logic        a_ar_ready, a_r_valid, b_ar_ready, b_r_valid;
   logic [31:0] a_r_data, b_r_data;
   int          n_assert = 0, n_fail = 0;
   int          sa, sb, sra, srb;
   logic [31:0] cyc = 0;
   logic [31:0] ata[$], atb[$], ra[$], rb[$], rta[$], rtb[$];
   logic [31:0] exp_mem [10];

   always #5 clk = ~clk;

   bram_sdp_flow #(.WIDTH(32), .DEPTH(10), .LATENCY(2), .RDW_MODE(0)) dut_a (
      .clk(clk), .reset(reset), .w_valid(w_valid), .w_address(w_address), .w_strb(w_strb),
      .w_data(w_data), .ar_valid(ar_valid), .ar_ready(a_ar_ready), .ar_address(ar_address),
      .r_valid(a_r_valid), .r_ready(r_ready), .r_data(a_r_data));

   bram_sdp_flow #(.WIDTH(32), .DEPTH(10), .LATENCY(3), .RDW_MODE(1)) dut_b (
      .clk(clk), .reset(reset), .w_valid(w_valid), .w_address(w_address), .w_strb(w_strb),
      .w_data(w_data), .ar_valid(ar_valid), .ar_ready(b_ar_ready), .ar_address(ar_address),
      .r_valid(b_r_valid), .r_ready(r_ready), .r_data(b_r_data));

   always @(posedge clk) begin
      if (ar_valid && a_ar_ready) ata.push_back(cyc);
      if (ar_valid && b_ar_ready) atb.push_back(cyc);
      if (a_r_valid && r_ready) begin ra.push_back(a_r_data); rta.push_back(cyc); end
      if (b_r_valid && r_ready) begin rb.push_back(b_r_data); rtb.push_back(cyc); end
      cyc = cyc + 1;
   end

   function automatic logic [31:0] qv(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 'x;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic mark();
      sa = ata.size(); sb = atb.size(); sra = ra.size(); srb = rb.size();
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      w_valid = 1; w_address = a; w_data = d; w_strb = s;
      tick(1);
      w_valid = 0;
   endtask

   task automatic check_one(input string tag, input logic [31:0] ea, input logic [31:0] eb);
      chk({tag, "_a_count"}, 32'(ra.size() - sra), 1);
      chk({tag, "_b_count"}, 32'(rb.size() - srb), 1);
      chk({tag, "_a_data"}, qv(ra, sra), ea);
      chk({tag, "_b_data"}, qv(rb, srb), eb);
      chk({tag, "_a_lat"}, qv(rta, sra) - qv(ata, sa), 3);
      chk({tag, "_b_lat"}, qv(rtb, srb) - qv(atb, sb), 4);
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] ea, input logic [31:0] eb);
      mark();
      ar_valid = 1; ar_address = a;
      tick(1);
      ar_valid = 0;
      tick(8);
      check_one(tag, ea, eb);
   endtask

   initial begin
      exp_mem = '{32'h100, 32'h101, 32'h102, 32'hFFFFFFFF, 32'h44444444,
                  32'hDEADBEEF, 32'h106, 32'h11BB33DD, 32'h108, 32'h109};
      tick(3);
      chk("rst_a_ar_ready", 32'(a_ar_ready), 0);
      chk("rst_b_ar_ready", 32'(b_ar_ready), 0);
      chk("rst_a_r_valid", 32'(a_r_valid), 0);
      chk("rst_b_r_valid", 32'(b_r_valid), 0);
      chk("rst_a_r_data", a_r_data, 0);
      chk("rst_b_r_data", b_r_data, 0);
      reset = 0;
      tick(1);
      chk("post_rst_a_ar_ready", 32'(a_ar_ready), 1);
      chk("post_rst_b_ar_ready", 32'(b_ar_ready), 1);

      for (int i = 0; i < 10; i++) wr(4'(i), 32'h100 + 32'(i), 4'hF);
      wr(4'd12, 32'hBAD0BAD0, 4'hF);

      // Backpressure: fill until credits run out, then drain in order.
      mark();
      ar_valid = 1;
      for (int i = 0; i < 10; i++) begin
         ar_address = 4'(i);
         tick(1);
      end
      ar_valid = 0;
      chk("bp_a_accepts", 32'(ata.size() - sa), 4);
      chk("bp_b_accepts", 32'(atb.size() - sb), 5);
      chk("bp_a_ar_ready", 32'(a_ar_ready), 0);
      chk("bp_b_ar_ready", 32'(b_ar_ready), 0);
      chk("bp_a_held", 32'(ra.size() - sra), 0);
      r_ready = 1;
      tick(10);
      chk("bp_a_resps", 32'(ra.size() - sra), 4);
      chk("bp_b_resps", 32'(rb.size() - srb), 5);
      for (int i = 0; i < 4; i++) chk($sformatf("bp_a_data%0d", i), qv(ra, sra + i), 32'h100 + 32'(i));
      for (int i = 0; i < 5; i++) chk($sformatf("bp_b_data%0d", i), qv(rb, srb + i), 32'h100 + 32'(i));

      wr(4'd5, 32'hDEADBEEF, 4'hF);
      rd_chk("wr_rd5", 4'd5, 32'hDEADBEEF, 32'hDEADBEEF);

      wr(4'd7, 32'h11223344, 4'hF);
      wr(4'd7, 32'hAABBCCDD, 4'b0101);
      rd_chk("strb7", 4'd7, 32'h11BB33DD, 32'h11BB33DD);

      wr(4'd3, 32'h0, 4'hF);
      mark();
      w_valid = 1; w_address = 4'd3; w_data = 32'hFFFFFFFF; w_strb = 4'hF;
      ar_valid = 1; ar_address = 4'd3;
      tick(1);
      w_valid = 0; ar_valid = 0;
      tick(8);
      check_one("rdw_same", 32'h0, 32'hFFFFFFFF);
      rd_chk("rdw_after", 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);

      mark();
      w_valid = 1; w_address = 4'd4; w_data = 32'h44444444; w_strb = 4'hF;
      ar_valid = 1; ar_address = 4'd2;
      tick(1);
      w_valid = 0; ar_valid = 0;
      tick(8);
      check_one("rdw_diff", 32'h102, 32'h102);

      rd_chk("oor12", 4'd12, 32'h0, 32'h0);

      // Sustained throughput with r_ready held high.
      mark();
      ar_valid = 1;
      for (int i = 0; i < 100; i++) begin
         ar_address = 4'(i % 10);
         tick(1);
      end
      ar_valid = 0;
      tick(10);
      chk("tp_a_accepts", 32'(ata.size() - sa), 100);
      chk("tp_b_accepts", 32'(atb.size() - sb), 100);
      chk("tp_a_span", qv(ata, sa + 99) - qv(ata, sa), 99);
      chk("tp_b_span", qv(atb, sb + 99) - qv(atb, sb), 99);
      chk("tp_a_resps", 32'(ra.size() - sra), 100);
      chk("tp_b_resps", 32'(rb.size() - srb), 100);
      for (int i = 0; i < 100; i++) begin
         chk($sformatf("tp_a_data%0d", i), qv(ra, sra + i), exp_mem[i % 10]);
         chk($sformatf("tp_b_data%0d", i), qv(rb, srb + i), exp_mem[i % 10]);
      end

      // Reset with three reads in flight discards them but keeps memory.
      r_ready = 0;
      mark();
      ar_valid = 1; ar_address = 4'd5;
      tick(3);
      ar_valid = 0;
      reset = 1;
      tick(1);
      chk("mid_rst_a_ar_ready", 32'(a_ar_ready), 0);
      chk("mid_rst_b_ar_ready", 32'(b_ar_ready), 0);
      tick(1);
      reset = 0;
      tick(1);
      chk("rel_a_ar_ready", 32'(a_ar_ready), 1);
      chk("rel_b_ar_ready", 32'(b_ar_ready), 1);
      chk("rel_a_r_valid", 32'(a_r_valid), 0);
      chk("rel_b_r_valid", 32'(b_r_valid), 0);
      r_ready = 1;
      tick(10);
      chk("inflight_a_accepts", 32'(ata.size() - sa), 3);
      chk("inflight_b_accepts", 32'(atb.size() - sb), 3);
      chk("inflight_a_resps", 32'(ra.size() - sra), 0);
      chk("inflight_b_resps", 32'(rb.size() - srb), 0);
      rd_chk("mem_kept", 4'd5, 32'hDEADBEEF, 32'hDEADBEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
